// File: rtl/btn_pkg.sv
// Shared types and helpers for the multi-channel button conditioner.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_t;

    // Milliseconds to sample-strobe count, rounded up and never below one sample.
    function automatic int unsigned ms_to_samples(input int unsigned ms, input int unsigned ce_hz);
        int unsigned n;
        n = (ms * ce_hz + 32'd999) / 32'd1000;
        return (n < 32'd1) ? 32'd1 : n;
    endfunction

endpackage

// File: rtl/btn_deb_chan.sv
// One button channel: synchroniser, debounce, hold/long/repeat FSM and pulse registers.
// Auto-repeat hardware is built only when BTN_AUTOREPEAT_EN is defined.
module btn_deb_chan
    import btn_pkg::*;
#(
    parameter bit          ACTIVE_LOW   = 1'b1,
    parameter int unsigned SAMPLES      = 20,
    parameter int unsigned LONG_SAMPLES = 1000
`ifdef BTN_AUTOREPEAT_EN
    , parameter int unsigned REPEAT_SAMPLES = 200
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_ce,
    input  logic btn_raw,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int unsigned CNT_W  = $clog2(SAMPLES + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_SAMPLES + 1);

    logic              sync1;
    logic              sync2;
    logic              sample_c;
    logic              last_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_nxt_c;
    logic              pressed_nxt_c;
    logic              rise_c;
    logic              fall_c;

    btn_state_t        state_q;
    btn_state_t        state_nxt_c;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_nxt_c;
    logic              long_fire_c;

    // Sync flops idle at the released pin level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= ACTIVE_LOW;
            sync2 <= ACTIVE_LOW;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    assign sample_c = sync2 ^ ACTIVE_LOW;

    always_comb begin
        cnt_nxt_c     = cnt_q;
        pressed_nxt_c = pressed;
        if (sample_ce) begin
            if (sample_c != last_q) begin
                cnt_nxt_c = CNT_W'(1);
            end else if (cnt_q != CNT_W'(SAMPLES)) begin
                cnt_nxt_c = cnt_q + CNT_W'(1);
            end
            if (cnt_nxt_c == CNT_W'(SAMPLES)) begin
                pressed_nxt_c = sample_c;
            end
        end
    end

    assign rise_c = pressed_nxt_c & ~pressed;
    assign fall_c = ~pressed_nxt_c & pressed;

    // Edge pulses are registered alongside the level, so they cover its first clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q        <= 1'b0;
            cnt_q         <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            if (sample_ce) begin
                last_q <= sample_c;
            end
            cnt_q         <= cnt_nxt_c;
            pressed       <= pressed_nxt_c;
            press_pulse   <= rise_c;
            release_pulse <= fall_c;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_SAMPLES + 1);

    logic [REP_W-1:0] rep_q;
    logic [REP_W-1:0] rep_nxt_c;
    logic             rep_fire_c;
`endif

    // Next-state logic; a release on the threshold CE pre-empts the long press.
    always_comb begin
        state_nxt_c = state_q;
        hold_nxt_c  = hold_q;
        long_fire_c = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        rep_nxt_c   = rep_q;
        rep_fire_c  = 1'b0;
`endif
        if (sample_ce) begin
            if (fall_c) begin
                state_nxt_c = IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rise_c) begin
                            state_nxt_c = HOLD;
                            hold_nxt_c  = '0;
                        end
                    end
                    HOLD: begin
                        if (hold_q != HOLD_W'(LONG_SAMPLES)) begin
                            hold_nxt_c = hold_q + HOLD_W'(1);
                            if (hold_nxt_c == HOLD_W'(LONG_SAMPLES)) begin
                                long_fire_c = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                                state_nxt_c = REPEAT;
                                rep_nxt_c   = '0;
`endif
                            end
                        end
                    end
`ifdef BTN_AUTOREPEAT_EN
                    REPEAT: begin
                        if (rep_q + REP_W'(1) == REP_W'(REPEAT_SAMPLES)) begin
                            rep_fire_c = 1'b1;
                            rep_nxt_c  = '0;
                        end else begin
                            rep_nxt_c = rep_q + REP_W'(1);
                        end
                    end
`endif
                    default: state_nxt_c = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            long_pulse <= 1'b0;
        end else begin
            state_q    <= state_nxt_c;
            hold_q     <= hold_nxt_c;
            long_pulse <= long_fire_c;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_q        <= '0;
            repeat_pulse <= 1'b0;
        end else begin
            rep_q        <= rep_nxt_c;
            repeat_pulse <= rep_fire_c;
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/btn_deb_multi_ce.sv
// N-channel button conditioner on a shared sample strobe; one btn_deb_chan per button.
// Define BTN_AUTOREPEAT_EN to build the auto-repeat stage.
module btn_deb_multi_ce
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN      = 4,
    parameter int unsigned STABLE_MS  = 20,
    parameter int unsigned CE_HZ      = 1000,
    parameter bit          ACTIVE_LOW = 1'b1,
    parameter int unsigned LONG_MS    = 1000,
    parameter int unsigned REPEAT_MS  = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_ce,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] pressed,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_pulse,
    output logic [N_BTN-1:0] repeat_pulse
);

    localparam int unsigned SAMPLES      = ms_to_samples(STABLE_MS, CE_HZ);
    localparam int unsigned LONG_SAMPLES = ms_to_samples(LONG_MS, CE_HZ);
`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned REPEAT_SAMPLES = ms_to_samples(REPEAT_MS, CE_HZ);
`endif

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_deb_chan #(
            .ACTIVE_LOW     (ACTIVE_LOW),
            .SAMPLES        (SAMPLES),
            .LONG_SAMPLES   (LONG_SAMPLES)
`ifdef BTN_AUTOREPEAT_EN
            , .REPEAT_SAMPLES (REPEAT_SAMPLES)
`endif
        ) u_chan (
            .clk           (clk),
            .rst_n         (rst_n),
            .sample_ce     (sample_ce),
            .btn_raw       (btn_raw[i]),
            .pressed       (pressed[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .long_pulse    (long_pulse[i]),
            .repeat_pulse  (repeat_pulse[i])
        );
    end

endmodule

// File: tb/tb_btn_deb_multi_ce.sv
// Bench for btn_deb_multi_ce: pulse scoreboard keyed by CE index plus a level-check vector table.
`timescale 1ns/1ps
module tb_btn_deb_multi_ce;

    localparam int unsigned N = 4;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         sample_ce = 1'b0;
    logic [N-1:0] raw_lo    = '1;
    logic [N-1:0] raw_hi    = '0;
    logic [N-1:0] pr_lo, pp_lo, rr_lo, lp_lo, rp_lo;
    logic [N-1:0] pr_hi, pp_hi, rr_hi, lp_hi, rp_hi;

    int n_checks = 0;
    int n_fail   = 0;
    int div      = 0;
    int ce_n     = 0;
    int obs_q[$];
    int exp_q[$];

    btn_deb_multi_ce #(
        .N_BTN(N), .STABLE_MS(4), .CE_HZ(1000), .ACTIVE_LOW(1'b1), .LONG_MS(10), .REPEAT_MS(3)
    ) dut_lo (
        .clk(clk), .rst_n(rst_n), .sample_ce(sample_ce), .btn_raw(raw_lo),
        .pressed(pr_lo), .press_pulse(pp_lo), .release_pulse(rr_lo),
        .long_pulse(lp_lo), .repeat_pulse(rp_lo)
    );

    btn_deb_multi_ce #(
        .N_BTN(N), .STABLE_MS(4), .CE_HZ(1000), .ACTIVE_LOW(1'b0), .LONG_MS(10), .REPEAT_MS(3)
    ) dut_hi (
        .clk(clk), .rst_n(rst_n), .sample_ce(sample_ce), .btn_raw(raw_hi),
        .pressed(pr_hi), .press_pulse(pp_hi), .release_pulse(rr_hi),
        .long_pulse(lp_hi), .repeat_pulse(rp_hi)
    );

    always #5 clk = ~clk;

    // sample_ce: one clk in every ten
    always @(negedge clk) begin
        sample_ce = (div == 9);
        div = (div == 9) ? 0 : div + 1;
    end

    always @(posedge clk) if (sample_ce) ce_n <= ce_n + 1;

    function automatic int enc(input int ce, input int inst, input int ch, input int kind);
        return ce * 1000 + inst * 100 + ch * 10 + kind;
    endfunction

    // Record every high pulse cycle, tagged with the CE index that produced it.
    always @(negedge clk) begin
        for (int c = 0; c < N; c++) begin
            if (pp_lo[c]) obs_q.push_back(enc(ce_n, 0, c, 0));
            if (rr_lo[c]) obs_q.push_back(enc(ce_n, 0, c, 1));
            if (lp_lo[c]) obs_q.push_back(enc(ce_n, 0, c, 2));
            if (rp_lo[c]) obs_q.push_back(enc(ce_n, 0, c, 3));
        end
        for (int c = 0; c < N; c++) begin
            if (pp_hi[c]) obs_q.push_back(enc(ce_n, 1, c, 0));
            if (rr_hi[c]) obs_q.push_back(enc(ce_n, 1, c, 1));
            if (lp_hi[c]) obs_q.push_back(enc(ce_n, 1, c, 2));
            if (rp_hi[c]) obs_q.push_back(enc(ce_n, 1, c, 3));
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step_ce(input int n);
        for (int i = 0; i < n; i++) begin
            int guard;
            guard = 0;
            @(posedge clk);
            while (!sample_ce && guard < 40) begin
                @(posedge clk);
                guard++;
            end
            if (!sample_ce) begin
                n_checks++;
                n_fail++;
                $display("FAIL ce_wait: no sample_ce within %0d clk", guard);
            end
            @(negedge clk);
        end
    endtask

    task automatic check_events(input string name);
        check({name, " event count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            int e;
            e = exp_q.pop_front();
            if (obs_q.size() == 0) check({name, " missing event"}, -1, e);
            else                   check({name, " event"}, obs_q.pop_front(), e);
        end
        while (obs_q.size() > 0) check({name, " extra event"}, obs_q.pop_front(), -1);
    endtask

    typedef struct {
        logic [3:0] raw;
        int         n_ce;
        logic [3:0] pr;
    } vec_t;

    vec_t vt[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        logic [3:0] prev;

        vt[0] = '{4'b1110, 3, 4'b0000};
        vt[1] = '{4'b1111, 3, 4'b0000};
        vt[2] = '{4'b1010, 4, 4'b0101};
        vt[3] = '{4'b1010, 1, 4'b0101};
        vt[4] = '{4'b1110, 3, 4'b0101};
        vt[5] = '{4'b1110, 1, 4'b0001};
        vt[6] = '{4'b1111, 4, 4'b0000};

        repeat (3) @(negedge clk);
        check("reset outputs lo", 32'({pr_lo, pp_lo, rr_lo, lp_lo, rp_lo}), 0);
        check("reset outputs hi", 32'({pr_hi, pp_hi, rr_hi, lp_hi, rp_hi}), 0);
        rst_n = 1'b1;
        step_ce(6);
        check("idle pressed lo", 32'(pr_lo), 0);
        check("idle pressed hi", 32'(pr_hi), 0);
        check_events("idle");

        // Bounce on ch0, then hold through long press and repeats, then release.
        e = ce_n;
        exp_q.push_back(enc(e + 8, 0, 0, 0));
        exp_q.push_back(enc(e + 18, 0, 0, 2));
`ifdef BTN_AUTOREPEAT_EN
        exp_q.push_back(enc(e + 21, 0, 0, 3));
        exp_q.push_back(enc(e + 24, 0, 0, 3));
        exp_q.push_back(enc(e + 27, 0, 0, 3));
`endif
        exp_q.push_back(enc(e + 28, 0, 0, 1));
        for (int k = 0; k < 5; k++) begin
            raw_lo[0] = ~raw_lo[0];
            step_ce(1);
        end
        step_ce(2);
        check("bounce pressed before 4th stable CE", 32'(pr_lo[0]), 0);
        step_ce(1);
        check("bounce pressed at 4th stable CE", 32'(pr_lo[0]), 1);
        step_ce(16);
        raw_lo[0] = 1'b1;
        step_ce(3);
        check("hold pressed before release", 32'(pr_lo[0]), 1);
        step_ce(1);
        check("pressed after release", 32'(pr_lo[0]), 0);
        step_ce(2);
        check_events("bounce long repeat");

        // Release debounce completes on the same CE as the long threshold.
        e = ce_n;
        exp_q.push_back(enc(e + 4, 0, 1, 0));
        exp_q.push_back(enc(e + 14, 0, 1, 1));
        raw_lo[1] = 1'b0;
        step_ce(10);
        raw_lo[1] = 1'b1;
        step_ce(4);
        check("release at long threshold pressed", 32'(pr_lo[1]), 0);
        step_ce(2);
        check_events("release beats long");

        // Level table: glitch rejection, two-channel press, staggered releases.
        prev = 4'b0000;
        for (int i = 0; i < 7; i++) begin
            for (int c = 0; c < 4; c++) begin
                if (vt[i].pr[c] != prev[c])
                    exp_q.push_back(enc(ce_n + vt[i].n_ce, 0, c, vt[i].pr[c] ? 0 : 1));
            end
            raw_lo = vt[i].raw;
            step_ce(vt[i].n_ce);
            check($sformatf("table row %0d pressed", i), 32'(pr_lo), 32'(vt[i].pr));
            prev = vt[i].pr;
        end
        step_ce(2);
        check_events("table");

        // Active-high instance: ch1 and ch3 together, others quiet.
        e = ce_n;
        exp_q.push_back(enc(e + 4, 1, 1, 0));
        exp_q.push_back(enc(e + 4, 1, 3, 0));
        exp_q.push_back(enc(e + 9, 1, 1, 1));
        exp_q.push_back(enc(e + 9, 1, 3, 1));
        raw_hi = 4'b1010;
        step_ce(4);
        check("polarity pressed hi", 32'(pr_hi), 32'(4'b1010));
        check("polarity pressed lo quiet", 32'(pr_lo), 0);
        step_ce(1);
        raw_hi = 4'b0000;
        step_ce(4);
        check("polarity released hi", 32'(pr_hi), 0);
        step_ce(2);
        check_events("multi channel");

        // Reset during hold: silent abort, then a fresh press from the still-held pin.
        e = ce_n;
        exp_q.push_back(enc(e + 4, 0, 2, 0));
        exp_q.push_back(enc(e + 10, 0, 2, 0));
        exp_q.push_back(enc(e + 14, 0, 2, 1));
        raw_lo[2] = 1'b0;
        step_ce(6);
        check("pre-reset pressed", 32'(pr_lo), 32'(4'b0100));
        rst_n = 1'b0;
        #1;
        check("async reset outputs", 32'({pr_lo, pp_lo, rr_lo, lp_lo, rp_lo}), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step_ce(4);
        check("re-debounced pressed", 32'(pr_lo), 32'(4'b0100));
        raw_lo[2] = 1'b1;
        step_ce(4);
        check("post-reset release", 32'(pr_lo), 0);
        step_ce(2);
        check_events("reset mid hold");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
